// File: rtl/inst_fetch_decode.sv
// Instruction fetch/decode sequencer: fetches one 32-bit word per instruction and issues it to a unit.
// Optional macro IFD_ILLEGAL_TRAP_EN: trap illegal opcodes into HALT instead of skipping them as NOPs.
module inst_fetch_decode #(
  parameter logic [3:0]  IMEM_SEL = 4'h8,
  parameter logic [11:0] PC_MAX   = 12'hFFF
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  output logic [15:0]  address,
  output logic         nRead,
  input  logic [255:0] InstrData,
  output logic [7:0]   Opcode,
  output logic [7:0]   Dest,
  output logic [7:0]   Src1,
  output logic [7:0]   Src2,
  output logic [3:0]   UnitSel,
  output logic         IssueValid,
  input  logic         IssueReady,
  output logic [11:0]  Pc,
  output logic         Busy,
  output logic         Halted,
  output logic         IllegalOp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t      state_reg, state_next;
  logic [11:0] pc_next;
  logic [15:0] address_next;
  logic        nread_next;
  logic [7:0]  opcode_next, dest_next, src1_next, src2_next;
  logic [3:0]  unit_next;
  logic        valid_next, busy_next, halted_next, illegal_next;
  logic        advance;

  // Byte 3 is the opcode, byte 0 is Src2.
  logic [7:0] instr_byte [4];
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign instr_byte[gi] = InstrData[gi*8 +: 8];
    end
  endgenerate

  // Only the low word carries the instruction.
  logic unused_bits;
  assign unused_bits = ^InstrData[255:32];

  logic is_matrix, is_integer, is_halt;
  assign is_matrix  = (instr_byte[3] <= 8'h05);
  assign is_integer = (instr_byte[3][7:2] == 6'b000100);
  assign is_halt    = (instr_byte[3] == 8'hFF);

  always_comb begin
    state_next   = state_reg;
    pc_next      = Pc;
    opcode_next  = Opcode;
    dest_next    = Dest;
    src1_next    = Src1;
    src2_next    = Src2;
    unit_next    = UnitSel;
    illegal_next = IllegalOp;
    advance      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (Start) begin
          state_next = S_FETCH;
          pc_next    = 12'h000;
        end
      end
      S_FETCH: state_next = S_WAIT;
      S_WAIT: begin
        opcode_next = instr_byte[3];
        dest_next   = instr_byte[2];
        src1_next   = instr_byte[1];
        src2_next   = instr_byte[0];
        if (is_matrix) begin
          state_next = S_ISSUE;
          unit_next  = 4'h2;
        end else if (is_integer) begin
          state_next = S_ISSUE;
          unit_next  = 4'h3;
        end else if (is_halt) begin
          state_next = S_HALT;
        end else begin
`ifdef IFD_ILLEGAL_TRAP_EN
          state_next   = S_HALT;
          illegal_next = 1'b1;
`else
          advance = 1'b1;
`endif
        end
      end
      S_ISSUE: begin
        if (IssueReady) advance = 1'b1;
      end
      S_HALT: begin
        if (Start) begin
          state_next   = S_FETCH;
          pc_next      = 12'h000;
          illegal_next = 1'b0;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // The PC never wraps: finishing the word at PC_MAX ends the program.
    if (advance) begin
      if (Pc == PC_MAX) begin
        state_next = S_HALT;
      end else begin
        pc_next    = Pc + 12'd1;
        state_next = S_FETCH;
      end
    end

    // Outputs are registered, so they are derived from the state being entered.
    nread_next   = (state_next != S_FETCH);
    address_next = (state_next == S_FETCH) ? {IMEM_SEL, pc_next} : 16'h0000;
    valid_next   = (state_next == S_ISSUE);
    busy_next    = (state_next == S_FETCH) || (state_next == S_WAIT) || (state_next == S_ISSUE);
    halted_next  = (state_next == S_HALT);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg  <= S_IDLE;
      Pc         <= 12'h000;
      address    <= 16'h0000;
      nRead      <= 1'b1;
      Opcode     <= 8'h00;
      Dest       <= 8'h00;
      Src1       <= 8'h00;
      Src2       <= 8'h00;
      UnitSel    <= 4'h0;
      IssueValid <= 1'b0;
      Busy       <= 1'b0;
      Halted     <= 1'b0;
      IllegalOp  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      Pc         <= pc_next;
      address    <= address_next;
      nRead      <= nread_next;
      Opcode     <= opcode_next;
      Dest       <= dest_next;
      Src1       <= src1_next;
      Src2       <= src2_next;
      UnitSel    <= unit_next;
      IssueValid <= valid_next;
      Busy       <= busy_next;
      Halted     <= halted_next;
      IllegalOp  <= illegal_next;
    end
  end

endmodule

// File: tb/tb_inst_fetch_decode.sv
// Directed bench for inst_fetch_decode: a default-parameter instance plus a PC_MAX=2 instance
// sharing one registered instruction memory model.
module tb_inst_fetch_decode;

  logic         clk = 1'b0;
  logic         reset, start, ready;
  logic [255:0] instr, instr2;
  logic [31:0]  mem [16];

  logic [15:0] address, address2;
  logic        nread, nread2;
  logic [7:0]  opcode, dest, src1, src2, opcode2, dest2, src1_2, src2_2;
  logic [3:0]  unit_sel, unit_sel2;
  logic        valid, valid2, busy, busy2, halted, halted2, illegal, illegal2;
  logic [11:0] pc, pc2;

  int checks = 0;
  int failures = 0;
  int fetch_cnt = 0, xfer_cnt = 0, consec_err = 0;
  int fetch2_cnt = 0, xfer2_cnt = 0, f8003_cnt = 0;
  bit prev_low = 1'b0;

  always #5 clk = ~clk;

  inst_fetch_decode dut (
    .Clk(clk), .Reset(reset), .Start(start), .address(address), .nRead(nread),
    .InstrData(instr), .Opcode(opcode), .Dest(dest), .Src1(src1), .Src2(src2),
    .UnitSel(unit_sel), .IssueValid(valid), .IssueReady(ready), .Pc(pc),
    .Busy(busy), .Halted(halted), .IllegalOp(illegal)
  );

  inst_fetch_decode #(.PC_MAX(12'd2)) dut2 (
    .Clk(clk), .Reset(reset), .Start(start), .address(address2), .nRead(nread2),
    .InstrData(instr2), .Opcode(opcode2), .Dest(dest2), .Src1(src1_2), .Src2(src2_2),
    .UnitSel(unit_sel2), .IssueValid(valid2), .IssueReady(ready), .Pc(pc2),
    .Busy(busy2), .Halted(halted2), .IllegalOp(illegal2)
  );

  // Registered memory: data for a strobed address appears the following cycle.
  always @(posedge clk) begin
    if (!nread)  instr  <= {{7{32'hA5A5A5A5}}, mem[address[3:0]]};
    if (!nread2) instr2 <= {{7{32'hA5A5A5A5}}, mem[address2[3:0]]};
  end

  always @(posedge clk) begin
    if (!nread) fetch_cnt <= fetch_cnt + 1;
    if (!nread && prev_low) consec_err <= consec_err + 1;
    prev_low <= !nread;
    if (valid && ready) xfer_cnt <= xfer_cnt + 1;
    if (!nread2) fetch2_cnt <= fetch2_cnt + 1;
    if (!nread2 && address2 == 16'h8003) f8003_cnt <= f8003_cnt + 1;
    if (valid2 && ready) xfer2_cnt <= xfer2_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic [31:0] w0, input logic [31:0] w1,
                      input logic [31:0] w2, input logic [31:0] w3);
    for (int i = 0; i < 16; i++) mem[i] = 32'hFFFFFFFF;
    mem[0] = w0;
    mem[1] = w1;
    mem[2] = w2;
    mem[3] = w3;
  endtask

  function automatic logic [68:0] outs();
    return {pc, address, nread, opcode, dest, src1, src2, unit_sel, valid, busy, halted, illegal};
  endfunction

  localparam logic [68:0] RESET_OUTS = {12'h000, 16'h0000, 1'b1, 32'h0, 4'h0, 4'h0};

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    tick();
    checks++;
    if (outs() !== RESET_OUTS) begin
      failures++;
      $display("FAIL reset_values got=%h want=%h", outs(), RESET_OUTS);
    end
    reset = 1'b0;
    start = 1'b0;
    tick();
    checks++;
    if ({busy, nread} !== 2'b01) begin
      failures++;
      $display("FAIL reset_idle busy,nread got=%b want=01", {busy, nread});
    end
    $display("tb: test_reset done");
  endtask

  task automatic test_first_issue();
    do_reset();
    load(32'h01020001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({nread, address} !== {1'b0, 16'h8000}) begin
      failures++;
      $display("FAIL first_fetch nread,addr got=%b,%h want=0,8000", nread, address);
    end
    tick();
    checks++;
    if ({nread, valid, busy} !== 3'b101) begin
      failures++;
      $display("FAIL first_wait nread,valid,busy got=%b want=101", {nread, valid, busy});
    end
    tick();
    checks++;
    if ({valid, opcode, dest, src1, src2, unit_sel} !== {1'b1, 32'h01020001, 4'h2}) begin
      failures++;
      $display("FAIL first_issue got=%b %h %h %h %h %h want=1 01 02 00 01 2",
               valid, opcode, dest, src1, src2, unit_sel);
    end
    tick();
    checks++;
    if ({valid, nread, address} !== {2'b00, 16'h8001}) begin
      failures++;
      $display("FAIL next_fetch valid,nread,addr got=%b,%b,%h want=0,0,8001", valid, nread, address);
    end
    $display("tb: test_first_issue op=%h unit=%h", opcode, unit_sel);
  endtask

  task automatic test_unit3_halt();
    int n = 0;
    int seen = 0;
    int x0;
    logic [3:0] cap_unit = 4'h0;
    do_reset();
    load(32'h120A0001, 32'hFFFFFFFF, 32'h01000000, 32'h01000000);
    ready = 1'b1;
    x0 = xfer_cnt;
    start = 1'b1;
    while (n < 30) begin
      tick();
      start = 1'b0;
      n++;
      if (valid) begin
        seen++;
        cap_unit = unit_sel;
      end
      if (halted) break;
    end
    checks++;
    if ({halted, busy, pc} !== {2'b10, 12'h001}) begin
      failures++;
      $display("FAIL halt_status halted,busy,pc got=%b,%b,%h want=1,0,001", halted, busy, pc);
    end
    checks++;
    if (n !== 6) begin
      failures++;
      $display("FAIL halt_latency cycles got=%0d want=6", n);
    end
    checks++;
    if ({seen, xfer_cnt - x0} !== {32'd1, 32'd1}) begin
      failures++;
      $display("FAIL unit3_issue_count valid_cycles=%0d xfers=%0d want=1,1", seen, xfer_cnt - x0);
    end
    checks++;
    if (cap_unit !== 4'h3) begin
      failures++;
      $display("FAIL unit3_sel got=%h want=3", cap_unit);
    end
    tick();
    checks++;
    if ({halted, nread} !== 2'b11) begin
      failures++;
      $display("FAIL halt_stays got=%b want=11", {halted, nread});
    end
    $display("tb: test_unit3_halt issues=%0d pc=%h", seen, pc);
  endtask

  task automatic test_stall();
    int f0;
    bit stable = 1'b1;
    do_reset();
    load(32'h03112233, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    f0 = fetch_cnt;
    for (int i = 0; i < 5; i++) begin
      if ({valid, nread, opcode, dest, src1, src2, unit_sel} !== {2'b11, 32'h03112233, 4'h2})
        stable = 1'b0;
      tick();
    end
    checks++;
    if (stable !== 1'b1) begin
      failures++;
      $display("FAIL stall_stable got=%b want=1", stable);
    end
    checks++;
    if (fetch_cnt !== f0) begin
      failures++;
      $display("FAIL stall_no_fetch fetches got=%0d want=%0d", fetch_cnt, f0);
    end
    ready = 1'b1;
    tick();
    checks++;
    if ({valid, nread, address, pc} !== {2'b00, 16'h8001, 12'h001}) begin
      failures++;
      $display("FAIL stall_release valid,nread,addr,pc got=%b,%b,%h,%h want=0,0,8001,001",
               valid, nread, address, pc);
    end
    $display("tb: test_stall released addr=%h", address);
  endtask

  task automatic test_illegal();
    int x0;
    do_reset();
    load(32'h7F000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    ready = 1'b1;
    x0 = xfer_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
`ifdef IFD_ILLEGAL_TRAP_EN
    checks++;
    if ({illegal, halted, busy, valid, pc} !== {4'b1100, 12'h000}) begin
      failures++;
      $display("FAIL illegal_trap ill,halt,busy,valid,pc got=%b%b%b%b,%h want=1100,000",
               illegal, halted, busy, valid, pc);
    end
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({illegal, halted} !== 2'b00) begin
      failures++;
      $display("FAIL illegal_clear got=%b want=00", {illegal, halted});
    end
`else
    checks++;
    if ({illegal, valid, nread, address} !== {3'b000, 16'h8001}) begin
      failures++;
      $display("FAIL illegal_nop ill,valid,nread,addr got=%b%b%b,%h want=000,8001",
               illegal, valid, nread, address);
    end
    checks++;
    if (xfer_cnt !== x0) begin
      failures++;
      $display("FAIL illegal_no_issue xfers got=%0d want=%0d", xfer_cnt - x0, 0);
    end
`endif
    $display("tb: test_illegal ill=%b addr=%h", illegal, address);
  endtask

  task automatic test_reset_mid_issue();
    do_reset();
    load(32'h01020001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_issue_valid got=%b want=1", valid);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (outs() !== RESET_OUTS) begin
      failures++;
      $display("FAIL mid_issue_reset got=%h want=%h", outs(), RESET_OUTS);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({nread, address} !== {1'b0, 16'h8000}) begin
      failures++;
      $display("FAIL refetch nread,addr got=%b,%h want=0,8000", nread, address);
    end
    $display("tb: test_reset_mid_issue refetch addr=%h", address);
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int x0, f0;
    do_reset();
    load(32'h00010203, 32'h10000000, 32'h05FFFFFF, 32'h01000000);
    ready = 1'b1;
    x0 = xfer2_cnt;
    f0 = fetch2_cnt;
    start = 1'b1;
    while (n < 40) begin
      tick();
      start = 1'b0;
      n++;
      if (halted2) break;
    end
    checks++;
    if ({halted2, busy2, pc2} !== {2'b10, 12'h002}) begin
      failures++;
      $display("FAIL pcmax_halt halted,busy,pc got=%b,%b,%h want=1,0,002", halted2, busy2, pc2);
    end
    checks++;
    if ({xfer2_cnt - x0, fetch2_cnt - f0, f8003_cnt} !== {32'd3, 32'd3, 32'd0}) begin
      failures++;
      $display("FAIL pcmax_counts xfers=%0d fetches=%0d f8003=%0d want=3,3,0",
               xfer2_cnt - x0, fetch2_cnt - f0, f8003_cnt);
    end
    checks++;
    if (n !== 10) begin
      failures++;
      $display("FAIL b2b_cycles got=%0d want=10", n);
    end
    checks++;
    if (consec_err !== 0) begin
      failures++;
      $display("FAIL nread_consecutive got=%0d want=0", consec_err);
    end
    $display("tb: test_back_to_back issues=%0d cycles=%0d", xfer2_cnt - x0, n);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    load(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    test_reset();
    test_first_issue();
    test_unit3_halt();
    test_stall();
    test_illegal();
    test_reset_mid_issue();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_decode.md
INST_FETCH_DECODE -- requirements
Module: inst_fetch_decode

Interface
REQ-001 SHALL have parameter IMEM_SEL, default 4'h8: address[15:12] value that selects instruction memory.
REQ-002 SHALL have parameter PC_MAX, default 12'hFFF: last legal PC; the fetch after PC_MAX halts.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Clk  input  1  rising-edge clock for all state.
REQ-005 Reset  input  1  synchronous active-high reset.
REQ-006 Start  input  1  one-cycle pulse; begins execution at PC 0.
REQ-007 address  output  16  {IMEM_SEL, Pc} in FETCH, else 16'h0000.
REQ-008 nRead  output  1  active-low read strobe to instruction memory.
REQ-009 InstrData  input  256  registered memory read data; instruction is bits [31:0].
REQ-010 Opcode/Dest/Src1/Src2  output  8 each  instruction bytes [31:24]/[23:16]/[15:8]/[7:0].
REQ-011 UnitSel  output  4  target unit: 4'h2 Matrix ALU, 4'h3 Integer ALU.
REQ-012 IssueValid  output  1  decoded instruction on outputs; IssueReady  input  1  unit accepts.
REQ-013 Pc  output  12; Busy, Halted, IllegalOp  output  1 each  status.

Function
REQ-014 SHALL implement FSM IDLE, FETCH, WAIT, ISSUE, HALT; all outputs registered.
REQ-015 IDLE: Start=1 -> FETCH, Pc=0; Start ignored in all states except IDLE and HALT.
REQ-016 FETCH (exactly 1 cycle): nRead=0, address={IMEM_SEL,Pc}; -> WAIT.
REQ-017 WAIT (1 cycle): nRead=1; at end, latch InstrData[31:0] into Opcode/Dest/Src1/Src2 and decode.
REQ-018 Decode: opcode 8'h00-8'h05 -> ISSUE, UnitSel=4'h2; 8'h10-8'h13 -> ISSUE, UnitSel=4'h3; 8'hFF -> HALT, no issue.
REQ-019 Any other opcode is illegal; handling per REQ-031/032.
REQ-020 ISSUE: IssueValid=1; Opcode/Dest/Src1/Src2/UnitSel held stable until IssueValid&&IssueReady at a rising edge.
REQ-021 On transfer: IssueValid=0 next cycle; Pc==PC_MAX -> HALT; else Pc=Pc+1, -> FETCH.
REQ-022 Fetch-to-IssueValid latency 2 cycles; back-to-back issue with IssueReady=1 every 3 cycles.
REQ-023 HALT: Halted=1, nRead=1; Start=1 -> FETCH, Pc=0, Halted=0, IllegalOp=0.
REQ-024 Busy=1 in FETCH, WAIT, ISSUE; 0 in IDLE, HALT.
REQ-025 nRead low only in FETCH; never low on consecutive cycles.
REQ-026 IssueReady asserted outside ISSUE SHALL have no effect.
REQ-027 Pc increment never wraps past PC_MAX; Pc=PC_MAX fetch followed by issue halts with Pc=PC_MAX.

Reset
REQ-028 Reset=1 at a rising edge SHALL force IDLE from any state, including mid-ISSUE with IssueValid=1.
REQ-029 Reset values: Pc=0, address=16'h0000, nRead=1, Opcode/Dest/Src1/Src2=8'h00, UnitSel=4'h0, IssueValid=0, Busy=0, Halted=0, IllegalOp=0.
REQ-030 Reset SHALL take priority over Start in the same cycle.

Configuration
REQ-031 Macro IFD_ILLEGAL_TRAP_EN defined: illegal opcode -> HALT, IllegalOp=1, Halted=1, Pc holds the faulting address, no issue.
REQ-032 Macro IFD_ILLEGAL_TRAP_EN undefined: illegal opcode treated as NOP -> no issue, IllegalOp stays 0, Pc=Pc+1 (or HALT at PC_MAX), -> FETCH.

Verification
REQ-033 Reset, Start, memory word0=32'h01_02_00_01, IssueReady=1 -> nRead low 1 cycle with address=16'h8000; 2 cycles later IssueValid=1, Opcode=01, Dest=02, Src1=00, Src2=01, UnitSel=2.
REQ-034 Words 12_0A_00_01, FF_FF_FF_FF -> one issue with UnitSel=3, then Halted=1, Busy=0, Pc=1, no second IssueValid.
REQ-035 IssueReady=0 for 5 cycles during ISSUE -> outputs stable, no new nRead; IssueReady=1 -> FETCH of Pc+1 next cycle.
REQ-036 Word 8'h7F_00_00_00 -> with IFD_ILLEGAL_TRAP_EN: IllegalOp=1, Halted=1, Pc=0; without: no issue, next fetch at address 16'h8001.
REQ-037 Reset asserted while IssueValid=1 -> next cycle all outputs at reset values; Start then refetches 16'h8000.
REQ-038 PC_MAX=12'd2, three legal words, IssueReady=1 -> three issues then Halted=1 with Pc=2, no fetch at 16'h8003.
